viterbi_frame_ctrl: RTL and testbench

Frame sequencer and channel scheduler for the encoder -> channel -> Viterbi decoder datapath. Per frame it:
- pulls FRAME_LEN payload bits from a bit source over a valid/ready handshake;
- drives the encoder enable and data, then appends TAIL_LEN zero flush bits;
- schedules burst bit-error injection into the channel;
- compares decoder output against a latency-matched copy of the transmitted bits, counting injected and residual bit errors.
Sits beside encoder and decoder in the tx/rx top and replaces free-running test-bench sequencing.

---
 rtl/viterbi_ctrl_pkg.sv | 23 ++
 rtl/viterbi_ref_delay.sv | 35 +++
 rtl/viterbi_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/viterbi_ctrl_pkg.sv
// viterbi_ctrl_pkg: shared state type, counter width, default parameters and saturating increment.
// Defaults for the error-burst pattern exist only when VITERBI_ERR_INJ_EN is defined.
package viterbi_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, DATA, TAIL, DRAIN, DONE} state_t;

    localparam int CNT_W         = 16;
    localparam int DEF_FRAME_LEN = 64;
    localparam int DEF_TAIL_LEN  = 2;
    localparam int DEF_DEC_LAT   = 32;
`ifdef VITERBI_ERR_INJ_EN
    localparam int DEF_ENC_LAT    = 1;
    localparam int DEF_ERR_PERIOD = 32;
    localparam int DEF_ERR_BURST  = 4;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W - 1){1'b0}}, n};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/viterbi_ref_delay.sv
// viterbi_ref_delay: DEPTH-stage {valid,data} shift line.
// any_valid_o flags valid entries (input included) that have not yet reached the tap.
module viterbi_ref_delay #(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    input  logic in_data_i,
    output logic out_valid_o,
    output logic out_data_o,
    output logic any_valid_o
);
    logic [DEPTH-1:0] v_q, v_d, d_q, d_d;

    always_comb begin
        v_d         = DEPTH'({v_q, in_valid_i});
        d_d         = DEPTH'({d_q, in_data_i});
        any_valid_o = |v_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign out_valid_o = v_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: per-frame sequencer for encoder -> channel -> Viterbi decoder with error counting.
// Burst error injection is compiled in only when VITERBI_ERR_INJ_EN is defined.
module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int TAIL_LEN   = DEF_TAIL_LEN,
`ifdef VITERBI_ERR_INJ_EN
    parameter int ENC_LAT    = DEF_ENC_LAT,
    parameter int ERR_PERIOD = DEF_ERR_PERIOD,
    parameter int ERR_BURST  = DEF_ERR_BURST,
`endif
    parameter int DEC_LAT    = DEF_DEC_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             src_valid_i,
    input  logic             src_data_i,
    output logic             src_ready_o,
    output logic             enc_enable_o,
    output logic             enc_data_o,
    output logic [1:0]       err_mask_o,
    input  logic             dec_data_i,
    output logic [CNT_W-1:0] bit_err_ct_o,
    output logic [CNT_W-1:0] inj_err_ct_o
);
    localparam int SYM = FRAME_LEN + TAIL_LEN;
    localparam int PW  = $clog2(SYM + 1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d, ready_q, ready_d, done_q, done_d;
    logic             en_q, en_d, dat_q, dat_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             hs, clr, ref_v, ref_d, ref_any, mask_any;

    viterbi_ref_delay #(.DEPTH(DEC_LAT)) u_ref (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (en_q),
        .in_data_i   (dat_q),
        .out_valid_o (ref_v),
        .out_data_o  (ref_d),
        .any_valid_o (ref_any)
    );

    always_comb begin
        hs      = ready_q & src_valid_i;
        clr     = (state_q == IDLE) & start_i;
        en_d    = hs | (state_q == TAIL);
        dat_d   = hs & src_data_i;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                state_d = start_i ? DATA : IDLE;
                cnt_d   = '0;
            end
            DATA: if (hs) begin
                cnt_d   = (cnt_q == PW'(FRAME_LEN - 1)) ? '0 : cnt_q + PW'(1);
                state_d = (cnt_q != PW'(FRAME_LEN - 1)) ? DATA : (TAIL_LEN > 0) ? TAIL : DRAIN;
            end
            TAIL: begin
                cnt_d   = (cnt_q == PW'(TAIL_LEN - 1)) ? '0 : cnt_q + PW'(1);
                state_d = (cnt_q == PW'(TAIL_LEN - 1)) ? DRAIN : TAIL;
            end
            // leave only once every transmitted bit has been compared
            DRAIN: state_d = (ref_any | mask_any) ? DRAIN : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = state_d != IDLE;
        ready_d = state_d == DATA;
        done_d  = state_d == DONE;
        bit_d   = clr ? '0 : (ref_v & (dec_data_i != ref_d)) ? sat_inc(bit_q, 2'd1) : bit_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            dat_q   <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            en_q    <= en_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    assign busy_o       = busy_q;
    assign src_ready_o  = ready_q;
    assign done_o       = done_q;
    assign enc_enable_o = en_q;
    assign enc_data_o   = dat_q;
    assign bit_err_ct_o = bit_q;

`ifdef VITERBI_ERR_INJ_EN
    logic [PW-1:0]    pos_q, pos_d;
    logic [CNT_W-1:0] inj_q, inj_d;
    logic             raw, m_v, m_d;

    viterbi_ref_delay #(.DEPTH(ENC_LAT)) u_mask (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (en_q),
        .in_data_i   (raw),
        .out_valid_o (m_v),
        .out_data_o  (m_d),
        .any_valid_o (mask_any)
    );

    assign err_mask_o   = {1'b0, m_v & m_d};
    assign inj_err_ct_o = inj_q;

    always_comb begin
        raw   = 32'(pos_q) % ERR_PERIOD >= ERR_PERIOD - ERR_BURST;
        pos_d = clr ? '0 : en_q ? pos_q + PW'(1) : pos_q;
        inj_d = clr ? '0 : sat_inc(inj_q, {1'b0, err_mask_o[1]} + {1'b0, err_mask_o[0]});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q <= '0;
            inj_q <= '0;
        end else begin
            pos_q <= pos_d;
            inj_q <= inj_d;
        end
    end
`else
    assign err_mask_o   = 2'b00;
    assign inj_err_ct_o = '0;
    assign mask_any     = 1'b0;
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: directed frame checks of viterbi_frame_ctrl against an ideal delayed-copy decoder.
// Mask/injection expectations follow VITERBI_ERR_INJ_EN as seen by this file.
module tb_viterbi_frame_ctrl;
    localparam int FL = 64, TL = 2, DL = 32, NC = 256;
`ifdef VITERBI_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0, start_i = 1'b0, src_valid_i = 1'b0, src_data_i = 1'b0, dec_data_i = 1'b0;
    logic        busy_o, done_o, src_ready_o, enc_enable_o, enc_data_o;
    logic [1:0]  err_mask_o;
    logic [15:0] bit_err_ct_o, inj_err_ct_o;

    int          n_chk = 0, n_fail = 0;
    logic [63:0] pat = 64'hA5C3_0F96_5A3C_F069;
    logic        dh [NC];
    logic        eh [NC];
    int          sh [NC];
    int          first_en, last_en, en_cnt, done_rel, n_done, data_err, mask_err, busy_cnt, ready_cnt;
    logic [15:0] bit_done, inj_done, bit_at1;
    logic        busy_after;

    always #5 clk = ~clk;

    viterbi_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .src_valid_i  (src_valid_i),
        .src_data_i   (src_data_i),
        .src_ready_o  (src_ready_o),
        .enc_enable_o (enc_enable_o),
        .enc_data_o   (enc_data_o),
        .err_mask_o   (err_mask_o),
        .dec_data_i   (dec_data_i),
        .bit_err_ct_o (bit_err_ct_o),
        .inj_err_ct_o (inj_err_ct_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame, cycle by cycle at negedge: sample outputs, then drive source and decoder model.
    task automatic run_frame(input bit hold, input bit gap, input int f1, input int f2, input int rst_at);
        int   acc, nsym;
        logic exp_m;
        first_en = -1; last_en = -1; en_cnt = 0; done_rel = -1; n_done = 0;
        data_err = 0; mask_err = 0; busy_cnt = 0; ready_cnt = 0;
        bit_done = 'x; inj_done = 'x; bit_at1 = 'x; busy_after = 1'bx;
        acc = 0; nsym = 0;
        for (int rel = 0; rel < NC; rel++) begin
            if (rel > 0) @(negedge clk);
            dh[rel] = enc_data_o;
            eh[rel] = enc_enable_o;
            sh[rel] = nsym;
            if (enc_enable_o) begin
                if (first_en < 0) first_en = rel;
                last_en = rel;
                en_cnt++;
                if (enc_data_o !== ((nsym < FL) ? pat[nsym] : 1'b0)) data_err++;
                nsym++;
            end
            exp_m = INJ && rel > 0 && eh[rel-1] && (sh[rel-1] % 32 >= 28);
            if (err_mask_o !== {1'b0, exp_m}) mask_err++;
            busy_cnt += int'(busy_o);
            ready_cnt += int'(src_ready_o);
            if (rel == 1) bit_at1 = bit_err_ct_o;
            if (done_o) begin
                n_done++;
                if (done_rel < 0) begin
                    done_rel = rel;
                    bit_done = bit_err_ct_o;
                    inj_done = inj_err_ct_o;
                end
            end
            if (done_rel >= 0 && rel == done_rel + 1) busy_after = busy_o;
            if (rel == rst_at) begin
                chk("rst.pre_en", {31'd0, enc_enable_o}, 1);
                rst = 1'b0;
                start_i = 1'b0;
                src_valid_i = 1'b0;
                #1;
                chk("rst.ctl", {25'd0, busy_o, done_o, src_ready_o, enc_enable_o, enc_data_o, err_mask_o}, 0);
                chk("rst.cnt", {bit_err_ct_o, inj_err_ct_o}, 0);
                break;
            end
            start_i = (rel == 0) || hold;
            src_valid_i = !(gap && rel >= 12 && rel <= 14);
            src_data_i = (acc < FL) ? pat[acc] : 1'b0;
            if (src_valid_i && src_ready_o) acc++;
            dec_data_i = (rel >= DL) ? dh[rel-DL] ^ (eh[rel-DL] && (sh[rel-DL] == f1 || sh[rel-DL] == f2)) : 1'b0;
            if (done_rel >= 0 && rel == done_rel + 1) break;
        end
    endtask

    task automatic check_frame(input string p, input int e_last, input int e_done, input int e_ready, input int e_bit);
        chk({p, ".first_en"}, first_en, 2);
        chk({p, ".last_en"}, last_en, e_last);
        chk({p, ".en_cnt"}, en_cnt, FL + TL);
        chk({p, ".done_cyc"}, done_rel, e_done);
        chk({p, ".done_pulses"}, n_done, 1);
        chk({p, ".busy_cyc"}, busy_cnt, e_done);
        chk({p, ".ready_cyc"}, ready_cnt, e_ready);
        chk({p, ".busy_after"}, {31'd0, busy_after}, 0);
        chk({p, ".data_err"}, data_err, 0);
        chk({p, ".mask_err"}, mask_err, 0);
        chk({p, ".bit_clr"}, {16'd0, bit_at1}, 0);
        chk({p, ".bit_err"}, {16'd0, bit_done}, e_bit);
        chk({p, ".inj_err"}, {16'd0, inj_done}, INJ ? 8 : 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("init.ctl", {25'd0, busy_o, done_o, src_ready_o, enc_enable_o, enc_data_o, err_mask_o}, 0);
        chk("init.cnt", {bit_err_ct_o, inj_err_ct_o}, 0);
        rst = 1'b1;
        @(negedge clk);
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check_frame("clean", 67, 100, 64, 0);
        @(negedge clk);
        run_frame(1'b0, 1'b1, -1, -1, -1);
        check_frame("gap", 70, 103, 67, 0);
        @(negedge clk);
        run_frame(1'b0, 1'b0, -1, -1, 30);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check_frame("post_rst", 67, 100, 64, 0);
        @(negedge clk);
        run_frame(1'b1, 1'b0, 5, 40, -1);
        check_frame("hold_flip", 67, 100, 64, 2);
        run_frame(1'b0, 1'b0, -1, -1, -1);
        check_frame("b2b", 67, 100, 64, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
